// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory between fetch and data ports with data priority
// and a fetch anti-starvation limit.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              stall_f,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              grant_d
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic                if_done_q, if_done_d, dm_done_q, dm_done_d, grant_d_q, grant_d_d;
  logic [3:0]          starve_q, starve_d;
  logic                fetch_win;
  assign fetch_win = if_req & (~dm_req | (starve_q == LIMIT));
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    grant_d_d   = grant_d_q;
    starve_d    = starve_q;
    case (state_q)
      IDLE: if (if_req | dm_req) begin
        mem_req_d = 1'b1;
        grant_d_d = ~fetch_win;
        if (fetch_win) begin
          state_d    = BUSY_I;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          starve_d   = 4'd0;
        end else begin
          state_d     = BUSY_D;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          // fetch wins once the count reaches LIMIT, so the increment saturates there
          starve_d    = if_req ? starve_q + 4'd1 : 4'd0;
        end
      end
      BUSY_I: if (mem_ack) begin
        state_d    = RESP;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        if_rdata_d = mem_rdata;
        if_done_d  = 1'b1;
      end
      BUSY_D: if (mem_ack) begin
        state_d    = RESP;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        dm_rdata_d = mem_we_q ? dm_rdata_q : mem_rdata;
        dm_done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      grant_d_q   <= 1'b0;
      starve_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      grant_d_q   <= grant_d_d;
      starve_q    <= starve_d;
    end
  end
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign grant_d   = grant_d_q;
  assign stall_f   = if_req & ~if_done_q;
  assign stall_m   = dm_req & ~dm_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with an in-order completion scoreboard and a
// wait-state-programmable memory responder.
module tb_mem_port_arbiter;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        if_done, dm_done, stall_f, stall_m, mem_req, mem_we, grant_d;
  logic        mem_ack = 1'b0;
  typedef struct { bit port; logic [31:0] data; } exp_t;
  exp_t        sb[$];
  logic [31:0] mem_model [logic [31:0]];
  int checks = 0, errors = 0, cyc = 0, wait_n = 0, if_done_cyc = 0, dm_done_cyc = 0, t0 = 0, n = 0;
  bit spur = 1'b0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .stall_f(stall_f),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant_d(grant_d)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory: acks after wait_n request cycles; when idle drives spur as a stray ack
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clock); #1;
      if (mem_req) begin
        if (cnt == wait_n) begin
          mem_ack = 1'b1;
          mem_rdata = mem_we ? 32'h0 : (mem_model.exists(mem_addr) ? mem_model[mem_addr] : ~mem_addr);
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack = spur;
        mem_rdata = 32'hBAD0BAD0;
        cnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && (if_done || dm_done)) begin
        chk("one_done", 32'(if_done & dm_done), 32'd0);
        if (if_done) if_done_cyc = cyc;
        if (dm_done) dm_done_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got if_done=%b dm_done=%b expected none", if_done, dm_done);
        end else begin
          e = sb.pop_front();
          chk("done_port", 32'(dm_done), 32'(e.port));
          chk("rdata", e.port ? dm_rdata : if_rdata, e.data);
          chk("grant_d", 32'(grant_d), 32'(e.port));
        end
      end
    end
  end

  task automatic fetch_txn(input logic [31:0] a);
    bit got = 1'b0;
    if_req = 1'b1;
    if_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (if_done) begin got = 1'b1; break; end
    end
    if (!got) chk("fetch_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bit got = 1'b0;
    dm_req = 1'b1;
    dm_we = we;
    dm_addr = a;
    dm_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (dm_done) begin got = 1'b1; break; end
    end
    if (!got) chk("data_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    dm_req = 1'b0;
  endtask

  initial begin
    mem_model[32'h40]  = 32'h8C010004;
    mem_model[32'h44]  = 32'h20420001;
    mem_model[32'h48]  = 32'h3C1D1000;
    mem_model[32'h4C]  = 32'h00004C4C;
    mem_model[32'h200] = 32'h11223344;
    mem_model[32'h204] = 32'h55667788;
    for (int i = 0; i < 5; i++) mem_model[32'h300 + 32'(4 * i)] = 32'hA0000000 + 32'(i);

    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_grant_d", 32'(grant_d), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    sb.push_back('{1'b0, 32'h8C010004});
    @(posedge clock); #1;
    if_req = 1'b1;
    if_addr = 32'h40;
    t0 = cyc;
    @(negedge clock);
    chk("f_stall_c0", 32'(stall_f), 32'd1);
    @(negedge clock);
    chk("f_mem_req_c1", 32'(mem_req), 32'd1);
    chk("f_mem_addr_c1", mem_addr, 32'h40);
    @(negedge clock);
    chk("f_stall_c2", 32'(stall_f), 32'd0);
    chk("f_done_c2", 32'(if_done), 32'd1);
    @(posedge clock); #1;
    if_req = 1'b0;
    chk("f_latency", 32'(if_done_cyc - t0), 32'd2);

    wait_n = 1;
    sb.push_back('{1'b1, 32'h11223344});
    data_txn(1'b0, 32'h200, 32'h0);

    wait_n = 2;
    sb.push_back('{1'b1, 32'h11223344});
    t0 = cyc;
    n = 0;
    fork
      data_txn(1'b1, 32'h100, 32'hDEADBEEF);
      repeat (8) begin
        @(negedge clock);
        if (mem_req && mem_we && mem_addr == 32'h100 && mem_wdata == 32'hDEADBEEF) n++;
      end
    join
    chk("w_req_cycles", 32'(n), 32'd3);
    chk("w_latency", 32'(dm_done_cyc - t0), 32'd4);
    chk("w_mem_written", mem_model[32'h100], 32'hDEADBEEF);

    wait_n = 0;
    sb.push_back('{1'b1, 32'h55667788});
    sb.push_back('{1'b0, 32'h20420001});
    fork
      data_txn(1'b0, 32'h204, 32'h0);
      fetch_txn(32'h44);
    join
    chk("sim_gap", 32'(if_done_cyc - dm_done_cyc), 32'd3);

    for (int i = 0; i < 4; i++) sb.push_back('{1'b1, 32'hA0000000 + 32'(i)});
    sb.push_back('{1'b0, 32'h3C1D1000});
    sb.push_back('{1'b1, 32'hA0000004});
    fork
      fetch_txn(32'h48);
      for (int i = 0; i < 5; i++) data_txn(1'b0, 32'h300 + 32'(4 * i), 32'h0);
    join

    spur = 1'b1;
    repeat (4) @(negedge clock);
    chk("spur_idle_if_rdata", if_rdata, 32'h20420001 ^ 32'h20420001 ^ 32'h3C1D1000);
    sb.push_back('{1'b0, 32'h00004C4C});
    fetch_txn(32'h4C);
    repeat (3) @(negedge clock);
    spur = 1'b0;
    chk("spur_resp_if_rdata", if_rdata, 32'h00004C4C);
    chk("spur_dm_rdata", dm_rdata, 32'hA0000004);

    wait_n = 10;
    @(posedge clock); #1;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h400;
    repeat (3) @(negedge clock);
    chk("rst_mid_busy", 32'(mem_req), 32'd1);
    chk("rst_mid_grant", 32'(grant_d), 32'd1);
    #2;
    reset_n = 1'b0;
    dm_req = 1'b0;
    #1;
    chk("rst_async_mem_req", 32'(mem_req), 32'd0);
    chk("rst_async_addr", mem_addr, 32'd0);
    chk("rst_async_grant", 32'(grant_d), 32'd0);
    chk("rst_async_dm_rdata", dm_rdata, 32'd0);
    chk("rst_async_if_rdata", if_rdata, 32'd0);
    chk("rst_stall_m", 32'(stall_m), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (15) @(negedge clock);
    chk("post_rst_idle", 32'(mem_req), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes). Arbitrates requests with data priority and a fetch anti-starvation limit, sequences each transaction over a req/ack memory interface, and returns per-port done pulses. Generates stall_f and stall_m toward the hazard logic so the pipeline freezes while a port's access is outstanding.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_LIMIT, 4, consecutive data grants made while fetch is waiting before fetch is forced a grant (range 1..15)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request; held high until if_done sampled
if_addr  in  ADDR_W  fetch address; stable while if_req high
if_rdata  out  DATA_W  fetched instruction, valid from if_done cycle, held until next fetch completion
if_done  out  1  one-cycle completion pulse for fetch
stall_f  out  1  if_req & ~if_done (combinational)
dm_req  in  1  data request; held high until dm_done sampled
dm_we  in  1  1 = write, 0 = read; stable while dm_req high
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  load data, valid from dm_done cycle of a read, held otherwise
dm_done  out  1  one-cycle completion pulse for data
stall_m  out  1  dm_req & ~dm_done (combinational)
mem_req  out  1  registered request to memory
mem_we  out  1  registered write enable to memory
mem_addr  out  ADDR_W  registered address to memory
mem_wdata  out  DATA_W  registered write data to memory
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, any latency >= 0 wait cycles
grant_d  out  1  1 while current/last grant owner is data port (debug)

Behaviour:
- Reset (async, reset_n=0): state IDLE; mem_req, mem_we, if_done, dm_done, grant_d = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; starve counter = 0. Reset mid-transaction abandons it; no done pulse is issued.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: on clock edge, if any request: select winner, latch address/we/wdata into mem_* registers, set mem_req=1, go BUSY_I or BUSY_D. No request: stay.
- Priority: dm_req wins over if_req, unless both high and starve counter == STARVE_LIMIT, then fetch wins.
- Starve counter: +1 on each data grant made while if_req high (saturates at STARVE_LIMIT); cleared on any fetch grant or on a data grant made with if_req low.
- BUSY_x: mem_req held with stable address/data until mem_ack sampled high. On that edge: mem_req=0, mem_we=0; BUSY_I loads if_rdata<=mem_rdata, asserts if_done; BUSY_D asserts dm_done and loads dm_rdata<=mem_rdata only if read; go RESP.
- RESP: exactly one cycle; done pulse visible; no arbitration, requests ignored (requester deasserts or re-presents next request). Next state IDLE, done cleared.
- mem_ack outside BUSY_x ignored.
- Latency with zero-wait memory (ack in first mem_req cycle): req in cycle 0 -> mem_req cycle 1 -> done cycle 2. Each wait cycle adds one. Peak throughput one transaction per 3 cycles.
- A port never receives done without having req high; at most one of if_done/dm_done high in any cycle.
- Requests arriving during BUSY/RESP wait; stall outputs stay high meanwhile.

Test Plan:
- Reset: reset_n low with mem_req active mid-BUSY_D -> all outputs 0 immediately, no dm_done after release, state IDLE.
- Single fetch, zero-wait: if_req, if_addr=0x40, mem_ack in first cycle with mem_rdata=0x8C010004 -> mem_addr=0x40 cycle 1, if_done and if_rdata=0x8C010004 cycle 2, stall_f low cycle 2.
- Data write, 2 wait states: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_req/mem_we high 3 cycles, dm_done cycle 4, dm_rdata unchanged.
- Simultaneous requests: both high in IDLE -> data granted first (grant_d=1), fetch granted in IDLE after RESP; fetch done 3 cycles after dm_done.
- Starvation: if_req held, dm_req re-asserted every IDLE, STARVE_LIMIT=4 -> exactly 4 data grants then fetch grant; counter back to 0.
- Spurious mem_ack in IDLE and RESP -> no done pulse, no rdata change.
